// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state
// encoding and the architectural zero-register index.
package pipe_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_e;

  // Register r0 is hard-wired to zero, so it can never create a hazard.
  localparam logic [4:0] REG_ZERO = 5'd0;

  // Width of the memory-wait counter; large enough for TIMEOUT_CYCLES up to 255.
  localparam int WAIT_W = 8;

endpackage

// File: rtl/pipe_hazard_ctrl_detect.sv
// Load-use hazard detector: flags an instruction in ID that reads the
// destination of a load currently in EX. Purely combinational.
module pipe_hazard_detect
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic [4:0] ID_rs,
  input  logic [4:0] ID_rt,
  input  logic [4:0] EX_rt,
  input  logic       EX_MemRead,
  output logic       load_use
);

  // A load into r0 never produces a value, so it cannot cause a stall.
  always_comb begin
    load_use = EX_MemRead && (EX_rt != REG_ZERO) &&
               ((EX_rt == ID_rs) || (EX_rt == ID_rt));
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: arbitrates memory stalls, taken-branch
// flushes and load-use bubbles, and keeps stall/flush performance counters.
// Optional memory-wait timeout enabled by defining PIPE_HAZARD_CTRL_TIMEOUT_EN.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       ID_rs,
  input  logic [4:0]       ID_rt,
  input  logic [4:0]       EX_rt,
  input  logic             EX_MemRead,
  input  logic             EX_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             PC_write,
  output logic             IF_ID_write,
  output logic             EX_MEM_write,
  output logic             MEM_WB_write,
  output logic             IF_ID_flush,
  output logic             ID_EX_flush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             mem_timeout
);

  // Catch out-of-range timeout settings at elaboration time.
  if ((TIMEOUT_CYCLES < 2) || (TIMEOUT_CYCLES > 255)) begin : g_bad_timeout
    $error("pipe_hazard_ctrl: TIMEOUT_CYCLES must be within 2..255");
  end

  state_e           state_q, state_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             load_use;
  logic             mem_stall;
  logic             branch_flush;

  pipe_hazard_detect u_detect (
    .ID_rs      (ID_rs),
    .ID_rt      (ID_rt),
    .EX_rt      (EX_rt),
    .EX_MemRead (EX_MemRead),
    .load_use   (load_use)
  );

  assign mem_stall = mem_req && !mem_ready;

  // A taken branch only flushes when nothing of higher priority holds the pipe.
  assign branch_flush = (state_q != ERROR) && !mem_stall && EX_branch_taken;

  // Pipeline enables and bubbles, highest-priority condition first.
  always_comb begin
    PC_write     = 1'b1;
    IF_ID_write  = 1'b1;
    EX_MEM_write = 1'b1;
    MEM_WB_write = 1'b1;
    IF_ID_flush  = 1'b0;
    ID_EX_flush  = 1'b0;
    if (!rst) begin
      PC_write     = 1'b0;
      IF_ID_write  = 1'b0;
      EX_MEM_write = 1'b0;
      MEM_WB_write = 1'b0;
      IF_ID_flush  = 1'b1;
      ID_EX_flush  = 1'b1;
    end else if ((state_q == ERROR) || mem_stall) begin
      PC_write     = 1'b0;
      IF_ID_write  = 1'b0;
      EX_MEM_write = 1'b0;
      MEM_WB_write = 1'b0;
    end else if (EX_branch_taken) begin
      IF_ID_flush  = 1'b1;
      ID_EX_flush  = 1'b1;
    end else if (load_use) begin
      PC_write     = 1'b0;
      IF_ID_write  = 1'b0;
      ID_EX_flush  = 1'b1;
    end
  end

`ifdef PIPE_HAZARD_CTRL_TIMEOUT_EN
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(TIMEOUT_CYCLES - 1);

  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              mem_timeout_q, mem_timeout_d;

  // Wait counter restarts when a stall begins and counts every stalled MEM_WAIT cycle.
  always_comb begin
    wait_d = wait_q;
    if ((state_q == RUN) && mem_stall) begin
      wait_d = '0;
    end else if ((state_q == MEM_WAIT) && mem_stall) begin
      wait_d = wait_q + WAIT_W'(1);
    end
  end

  // Next state: stalls park in MEM_WAIT, a stall that runs too long is fatal.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN: begin
        if (mem_stall) state_d = MEM_WAIT;
      end
      MEM_WAIT: begin
        if (!mem_stall) begin
          state_d = RUN;
        end else if ((wait_q + WAIT_W'(1)) == WAIT_LIMIT) begin
          state_d = ERROR;
        end
      end
      ERROR: begin
        state_d = ERROR;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  // The timeout flag latches on entry to ERROR and only reset clears it.
  always_comb begin
    mem_timeout_d = mem_timeout_q || (state_d == ERROR);
  end

  // Timeout bookkeeping registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wait_q        <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      wait_q        <= wait_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  assign mem_timeout = mem_timeout_q;
`else
  // Next state: without the timeout a stall simply waits for mem_ready.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN: begin
        if (mem_stall) state_d = MEM_WAIT;
      end
      MEM_WAIT: begin
        if (!mem_stall) state_d = RUN;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  assign mem_timeout = 1'b0;
`endif

  // Performance counters saturate instead of wrapping so long runs stay meaningful.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if ((state_q != ERROR) && !PC_write && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (branch_flush && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  // State and counter registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= RUN;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl. Expected results are queued
// when stimulus is driven and compared when the DUT responds: the
// combinational enables mid-cycle, the registered counters after the edge.
// Timeout scenario is compiled in when PIPE_HAZARD_CTRL_TIMEOUT_EN is defined.
module tb_pipe_hazard_ctrl;

  localparam int CNT_W   = 4;
  localparam int TIMEOUT = 4;

  logic             clk;
  logic             rst;
  logic [4:0]       ID_rs, ID_rt, EX_rt;
  logic             EX_MemRead, EX_branch_taken, mem_req, mem_ready;
  logic             PC_write, IF_ID_write, EX_MEM_write, MEM_WB_write;
  logic             IF_ID_flush, ID_EX_flush;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic             mem_timeout;

  typedef struct {
    string      tag;
    logic [3:0] en;
    logic [1:0] fl;
    logic [3:0] stallCnt;
    logic [3:0] flushCnt;
    logic       tmo;
  } expect_t;

  expect_t expQ[$];
  int errors = 0;
  int checks = 0;

  pipe_hazard_ctrl #(
    .TIMEOUT_CYCLES (TIMEOUT),
    .CNT_W          (CNT_W)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .ID_rs           (ID_rs),
    .ID_rt           (ID_rt),
    .EX_rt           (EX_rt),
    .EX_MemRead      (EX_MemRead),
    .EX_branch_taken (EX_branch_taken),
    .mem_req         (mem_req),
    .mem_ready       (mem_ready),
    .PC_write        (PC_write),
    .IF_ID_write     (IF_ID_write),
    .EX_MEM_write    (EX_MEM_write),
    .MEM_WB_write    (MEM_WB_write),
    .IF_ID_flush     (IF_ID_flush),
    .ID_EX_flush     (ID_EX_flush),
    .stall_cnt       (stall_cnt),
    .flush_cnt       (flush_cnt),
    .mem_timeout     (mem_timeout)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Guard against a stuck run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  // Drive one cycle of inputs, queue what should come back, then compare.
  task automatic applyStimulus(input string tag, input logic rstV,
                               input logic memRead, input logic [4:0] exRt,
                               input logic [4:0] idRs, input logic [4:0] idRt,
                               input logic br, input logic req, input logic rdy,
                               input logic [3:0] expEn, input logic [1:0] expFl,
                               input logic [3:0] expStall, input logic [3:0] expFlush,
                               input logic expTmo);
    expect_t e;
    rst             = rstV;
    EX_MemRead      = memRead;
    EX_rt           = exRt;
    ID_rs           = idRs;
    ID_rt           = idRt;
    EX_branch_taken = br;
    mem_req         = req;
    mem_ready       = rdy;
    e.tag      = tag;
    e.en       = expEn;
    e.fl       = expFl;
    e.stallCnt = expStall;
    e.flushCnt = expFlush;
    e.tmo      = expTmo;
    expQ.push_back(e);
    @(negedge clk);
    e = expQ.pop_front();
    checkOutput({e.tag, ".en"}, {28'd0, PC_write, IF_ID_write, EX_MEM_write, MEM_WB_write},
                {28'd0, e.en});
    checkOutput({e.tag, ".fl"}, {30'd0, IF_ID_flush, ID_EX_flush}, {30'd0, e.fl});
    @(posedge clk);
    #1;
    checkOutput({e.tag, ".stall_cnt"}, {28'd0, stall_cnt}, {28'd0, e.stallCnt});
    checkOutput({e.tag, ".flush_cnt"}, {28'd0, flush_cnt}, {28'd0, e.flushCnt});
    checkOutput({e.tag, ".mem_timeout"}, {31'd0, mem_timeout}, {31'd0, e.tmo});
  endtask

  task automatic doReset(input string tag);
    applyStimulus(tag, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0,
                  4'b0000, 2'b11, 4'd0, 4'd0, 1'b0);
  endtask

  initial begin
    rst = 1'b0; EX_MemRead = 1'b0; EX_rt = '0; ID_rs = '0; ID_rt = '0;
    EX_branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
    @(posedge clk);
    #1;

    doReset("reset0");
    doReset("reset1");
    applyStimulus("normal", 1, 0, 5'd3, 5'd3, 5'd4, 0, 0, 0, 4'b1111, 2'b00, 4'd0, 4'd0, 0);

    applyStimulus("loaduse_rs", 1, 1, 5'd5, 5'd5, 5'd9, 0, 0, 0, 4'b0011, 2'b01, 4'd1, 4'd0, 0);
    applyStimulus("load_r0", 1, 1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 4'b1111, 2'b00, 4'd1, 4'd0, 0);
    applyStimulus("loaduse_rt", 1, 1, 5'd7, 5'd2, 5'd7, 0, 0, 0, 4'b0011, 2'b01, 4'd2, 4'd0, 0);
    applyStimulus("load_nomatch", 1, 1, 5'd7, 5'd2, 5'd3, 0, 0, 0, 4'b1111, 2'b00, 4'd2, 4'd0, 0);
    applyStimulus("noload_match", 1, 0, 5'd5, 5'd5, 5'd5, 0, 0, 0, 4'b1111, 2'b00, 4'd2, 4'd0, 0);

    doReset("reset2");
    applyStimulus("branch_loaduse", 1, 1, 5'd5, 5'd5, 5'd0, 1, 0, 0, 4'b1111, 2'b11, 4'd0, 4'd1, 0);
    applyStimulus("branch", 1, 0, 5'd0, 5'd0, 5'd0, 1, 0, 0, 4'b1111, 2'b11, 4'd0, 4'd2, 0);

    doReset("reset3");
    applyStimulus("memstall1", 1, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 4'b0000, 2'b00, 4'd1, 4'd0, 0);
    applyStimulus("memstall2_br", 1, 0, 5'd0, 5'd0, 5'd0, 1, 1, 0, 4'b0000, 2'b00, 4'd2, 4'd0, 0);
    applyStimulus("memstall3_lu", 1, 1, 5'd6, 5'd6, 5'd0, 0, 1, 0, 4'b0000, 2'b00, 4'd3, 4'd0, 0);
    applyStimulus("memready", 1, 0, 5'd0, 5'd0, 5'd0, 0, 1, 1, 4'b1111, 2'b00, 4'd3, 4'd0, 0);
    applyStimulus("after_wait", 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 4'b1111, 2'b00, 4'd3, 4'd0, 0);

    doReset("reset4");
    for (int i = 0; i < 20; i++) begin
      applyStimulus($sformatf("sat%0d", i), 1, 1, 5'd12, 5'd1, 5'd12, 0, 0, 0,
                    4'b0011, 2'b01, (i >= 14) ? 4'd15 : 4'(i + 1), 4'd0, 0);
    end

    doReset("reset5");
    for (int i = 0; i < 17; i++) begin
      applyStimulus($sformatf("fsat%0d", i), 1, 0, 5'd0, 5'd0, 5'd0, 1, 0, 0,
                    4'b1111, 2'b11, 4'd0, (i >= 14) ? 4'd15 : 4'(i + 1), 0);
    end

    doReset("reset6");
`ifdef PIPE_HAZARD_CTRL_TIMEOUT_EN
    for (int i = 0; i < TIMEOUT; i++) begin
      applyStimulus($sformatf("tmo_stall%0d", i), 1, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0,
                    4'b0000, 2'b00, 4'(i + 1), 4'd0, (i == TIMEOUT - 1));
    end
    applyStimulus("error_hold", 1, 0, 5'd0, 5'd0, 5'd0, 1, 0, 0, 4'b0000, 2'b00, 4'd4, 4'd0, 1);
    applyStimulus("error_ready", 1, 0, 5'd0, 5'd0, 5'd0, 0, 1, 1, 4'b0000, 2'b00, 4'd4, 4'd0, 1);
    doReset("error_reset");
    applyStimulus("post_error", 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 4'b1111, 2'b00, 4'd0, 4'd0, 0);
`else
    for (int i = 0; i < TIMEOUT + 3; i++) begin
      applyStimulus($sformatf("long_stall%0d", i), 1, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0,
                    4'b0000, 2'b00, 4'(i + 1), 4'd0, 0);
    end
    applyStimulus("long_ready", 1, 0, 5'd0, 5'd0, 5'd0, 0, 1, 1, 4'b1111, 2'b00, 4'd7, 4'd0, 0);
    applyStimulus("stall_again", 1, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 4'b0000, 2'b00, 4'd8, 4'd0, 0);
    doReset("midwait_reset");
    applyStimulus("post_reset", 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 4'b1111, 2'b00, 4'd0, 4'd0, 0);
`endif

    checkOutput("scoreboard_empty", 32'(expQ.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
